// File: rtl/dp_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// default geometry/latency, and the request legality check (alignment + range).
// No ports; imported by dmem_responder.
package dp_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    // Address is passed zero-extended to 64 bits so one function serves any ADDR_W.
    // Every upper bit participates in the range test, so an aliasing address
    // can never reach storage.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: DEPTH_WORDS x DATA_W, synchronous write, combinational read.
// Ports: clk_i; we_i write enable; idx_i word index shared by read and write;
//        wdata_i store data; rdata_o word at idx_i. Contents are never reset.
module dmem_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request (valid/ready), waits WAIT_CYCLES,
// performs the access once, then holds the response until resp_ready.
// Ports: CLK/RST (sync, active-high); req_* request channel; resp_* response channel;
//        busy = not idle, used by the datapath to stall MEM.
module dmem_responder
    import dp_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rerr_q, rerr_d;

    logic               req_err;
    logic [IDX_W-1:0]   req_idx;

    // Access-edge signals: sourced from the live request when there is no wait,
    // otherwise from the request captured at accept.
    logic               acc_en;
    logic               acc_wr;
    logic [IDX_W-1:0]   acc_idx;
    logic [DATA_W-1:0]  acc_wdata;
    logic               acc_err;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;

    assign req_err = addr_err(64'(req_addr), DEPTH_WORDS);
    assign req_idx = req_addr[IDX_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        acc_en    = 1'b0;
        acc_wr    = wr_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_err   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    if (WAIT_CYCLES == 0) begin
                        acc_en    = 1'b1;
                        acc_wr    = req_write;
                        acc_idx   = req_idx;
                        acc_wdata = req_wdata;
                        acc_err   = req_err;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    acc_en  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc_en) begin
            rdata_d = (acc_wr || acc_err) ? '0 : mem_rdata;
            rerr_d  = acc_err;
        end
    end

    // Reset must also block a store landing on the same edge.
    assign mem_we = acc_en && acc_wr && !acc_err && !RST;

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has no wait states, instance 1 has two.
// Directed scenarios then randomized traffic, scored against a word-array model.
// Ports: none (top-level bench).
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rv   [2];
    logic        rw   [2];
    logic [31:0] ra   [2];
    logic [31:0] rwd  [2];
    logic        rr   [2];
    logic        rrdy [2];
    logic        rsv  [2];
    logic [31:0] rsd  [2];
    logic        rse  [2];
    logic        bsy  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference storage: value and whether the word has ever been legally written.
    logic [31:0] ref_mem   [2][256];
    bit          ref_known [2][256];

    always #5 CLK = ~CLK;

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .req_valid(rv[0]), .req_ready(rrdy[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]),
        .resp_valid(rsv[0]), .resp_ready(rr[0]), .resp_rdata(rsd[0]),
        .resp_err(rse[0]), .busy(bsy[0])
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .CLK(CLK), .RST(RST),
        .req_valid(rv[1]), .req_ready(rrdy[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]),
        .resp_valid(rsv[1]), .resp_ready(rr[1]), .resp_rdata(rsd[1]),
        .resp_err(rse[1]), .busy(bsy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, ".req_ready"},  32'(rrdy[d]), 32'd1);
        chk({tag, ".resp_valid"}, 32'(rsv[d]),  32'd0);
        chk({tag, ".busy"},       32'(bsy[d]),  32'd0);
        chk({tag, ".rdata"},      rsd[d],       32'd0);
        chk({tag, ".err"},        32'(rse[d]),  32'd0);
    endtask

    // One full transaction on instance d, holding resp_ready low for 'hold' cycles.
    task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold);
        bit          exp_err;
        bit          rd_known;
        logic [31:0] exp_rd;
        int          lat;
        int          n;
        int unsigned w;
        lat     = (d == 0) ? 0 : 2;
        exp_err = (addr % 4 != 0) || (addr / 4 >= 256);
        w       = (addr / 4) % 256;
        if (exp_err || wr) begin
            exp_rd   = 32'd0;
            rd_known = 1'b1;
        end else begin
            exp_rd   = ref_mem[d][w];
            rd_known = ref_known[d][w];
        end
        if (wr && !exp_err) begin
            ref_mem[d][w]   = wd;
            ref_known[d][w] = 1'b1;
        end

        @(negedge CLK);
        rv[d] = 1'b1; rw[d] = wr; ra[d] = addr; rwd[d] = wd; rr[d] = 1'b0;
        n = 0;
        while (!rrdy[d] && n < 20) begin @(negedge CLK); n++; end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge CLK); #1;
        // Scramble request inputs: only the accept-edge values may matter.
        rv[d] = 1'b0; rw[d] = 1'($urandom); ra[d] = $urandom; rwd[d] = $urandom;
        n = 0;
        while (!rsv[d] && n < 20) begin @(posedge CLK); #1; n++; end
        chk("latency", 32'(n), 32'(lat));
        for (int i = 0; i <= hold; i++) begin
            chk("resp_valid", 32'(rsv[d]),  32'd1);
            chk("resp_err",   32'(rse[d]),  32'(exp_err));
            if (rd_known) chk("resp_rdata", rsd[d], exp_rd);
            chk("busy_resp",  32'(bsy[d]),  32'd1);
            chk("no_reaccept", 32'(rrdy[d]), 32'd0);
            if (i < hold) begin @(posedge CLK); #1; end
        end
        rr[d] = 1'b1;
        @(posedge CLK); #1;
        rr[d] = 1'b0;
        chk_idle(d, "post_hs");
    endtask

    task automatic rand_txn(input int d);
        logic [31:0] addr;
        case ($urandom_range(0, 3))
            0: addr = 32'($urandom_range(0, 15)) * 4;
            1: addr = 32'($urandom_range(252, 255)) * 4;
            2: addr = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            default: addr = $urandom;
        endcase
        txn(d, 1'($urandom), addr, $urandom, $urandom_range(0, 3));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = '0; rwd[d] = '0; rr[d] = 1'b0;
            for (int i = 0; i < 256; i++) begin
                ref_mem[d][i]   = '0;
                ref_known[d][i] = 1'b0;
            end
        end

        // Reset held for two cycles.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk_idle(0, "reset0");
        chk_idle(1, "reset2");
        RST = 1'b0;

        // Store then load, two wait states.
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 0);
        // Back-pressure for five cycles.
        txn(1, 1'b0, 32'h10, 32'h0, 5);
        // Misaligned store, out-of-range load, then prior value intact.
        txn(1, 1'b1, 32'h12, 32'h55555555, 1);
        txn(1, 1'b0, 32'h400, 32'h0, 0);
        txn(1, 1'b0, 32'h10, 32'h0, 0);

        // Reset during WAIT drops a pending store.
        txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, 0);
        @(negedge CLK);
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h20; rwd[1] = 32'h1234;
        @(posedge CLK); #1;
        rv[1] = 1'b0;
        chk("wait_busy", 32'(bsy[1]), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk_idle(1, "rst_wait");
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wait_noresp", 32'(rsv[1]), 32'd0);
        txn(1, 1'b0, 32'h20, 32'h0, 0);

        // Reset while in RESP drops the response.
        @(negedge CLK);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h10;
        @(posedge CLK); #1;
        rv[1] = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("resp_before_rst", 32'(rsv[1]), 32'd1);
        chk("resp_before_rst_d", rsd[1], 32'hDEADBEEF);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk_idle(1, "rst_resp");

        // Zero wait states: highest word legal, one past it is not.
        txn(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 2);
        txn(0, 1'b1, 32'h400, 32'h11111111, 0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            rand_txn(0);
            rand_txn(1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
